corr_scan: RTL
==============

Name: corr_scan

Overview:
- Upstream correlation stage feeding the argmax unit in the OMP processor.
- For each dictionary column j, computes the signed dot product of the current residual r with column j of theta.
- Streams each result as (corr_value, corr_idx = j) with a one-cycle corr_valid strobe.
- corr_valid drives the argmax unit's enable, corr_value its value input and corr_idx its idx input.

Parameters:
- DATA_W, 16, signed width of theta and residual RAM words.
- ACC_W, 40, signed accumulator / corr_value width; must be >= 2*DATA_W + clog2(M_ROWS).
- M_ROWS, 32, rows per column (residual length).
- N_COLS, 256, maximum number of dictionary columns.
- IDX_W, 8, column index width (clog2(N_COLS)).
- ROW_W, 5, clog2(M_ROWS).
- TADDR_W, 13, clog2(N_COLS*M_ROWS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- num_cols  in  IDX_W+1  columns to scan (0..N_COLS); sampled with start.
- theta_ren  out  1  theta RAM read enable.
- theta_addr  out  TADDR_W  theta address = col*M_ROWS + row.
- theta_rdata  in  DATA_W  signed theta word; valid exactly 1 cycle after theta_ren.
- res_ren  out  1  residual RAM read enable.
- res_addr  out  ROW_W  residual address = row.
- res_rdata  in  DATA_W  signed residual word; valid 1 cycle after res_ren.
- corr_valid  out  1  one-cycle strobe: corr_value/corr_idx hold a finished column.
- corr_value  out  ACC_W  signed dot product for column corr_idx.
- corr_idx  out  IDX_W  column index of corr_value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle strobe: scan complete.

Behaviour:
- Reset: all outputs are 0; FSM to IDLE; row/column counters and accumulator cleared. Reset mid-scan aborts immediately; no further corr_valid or done is produced.

FSM states:
- IDLE:
  - start=1 with num_cols>0: latch num_cols, go to RUN.
  - start=1 with num_cols=0: go to FIN; no reads and no corr_valid.
- RUN:
  - Every cycle: theta_ren=res_ren=1, issue (col,row); row increments.
  - Row wraps M_ROWS-1 -> 0 and col increments.
  - No bubbles within or between columns.
  - After issuing (num_cols-1, M_ROWS-1), go to DRAIN.
- DRAIN: wait for the pipeline to empty (2 cycles), then go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.

Datapath:
- Address issued in cycle k; data returns in cycle k+1.
- In cycle k+1, product p = theta_rdata*res_rdata (signed, 2*DATA_W) is sign-extended to ACC_W.
- At the end of cycle k+1: acc <= p if the data's row==0, else acc <= acc + p.
- Row/col tags are pipelined alongside the read.
- When the accumulated word's row == M_ROWS-1, corr_value <= acc + p and corr_idx <= its col are registered; corr_valid is high during the following cycle only.
- Arithmetic is two's complement, no saturation; the ACC_W sizing rule makes overflow impossible.

Timing (start accepted at edge E0; cycle 1 = first RUN cycle):
- Column j addresses are issued in cycles j*M_ROWS+1 .. (j+1)*M_ROWS.
- corr_valid for column j is high in cycle (j+1)*M_ROWS+2.
- Successive corr_valid strobes are exactly M_ROWS cycles apart.
- done is high in cycle num_cols*M_ROWS+3, one cycle after the last corr_valid.
- busy is high in cycles 1 .. num_cols*M_ROWS+2.

Boundary and ordering rules:
- start while busy or in FIN is ignored; a latched num_cols is never altered mid-scan.
- num_cols > N_COLS is clamped to N_COLS.
- corr_idx increases 0,1,..,num_cols-1 in order, each index exactly once, so the argmax unit sees idx==0 first.
- theta_addr and res_addr are 0 whenever the read enables are low.

Test Plan:
- M_ROWS=32, num_cols=1, theta col0 = all 1, residual = 1..32 -> one corr_valid in cycle 34 with corr_value=528, corr_idx=0; done in cycle 35.
- Theta col0 = all -32768, residual = all -32768, num_cols=1 -> corr_value = +34359738368 (2^35), no overflow; 0 when residual = all 0.
- num_cols=4, column j = all (j-2), residual = all 1 -> corr_valid in cycles 34,66,98,130 with values -64,-32,0,32 and idx 0..3; theta_ren high continuously in cycles 1..128.
- num_cols=0 with start -> done one cycle after FIN entry; no ren, no corr_valid; busy stays 0.
- start pulsed again at cycle 10 of a num_cols=2 scan -> ignored; exactly 2 corr_valid and 1 done.
- rst asserted at cycle 40 of a num_cols=3 scan -> all outputs 0 immediately; no corr_valid afterwards; a new start then yields a correct fresh scan starting at idx 0.

Source files
------------

// File: rtl/corr_scan_if.sv
// rtl/corr_scan_if.sv - request, RAM-read and correlation-result signals for corr_scan
interface corr_scan_if #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int IDX_W   = 8,
  parameter int ROW_W   = 5,
  parameter int TADDR_W = 13
);
  logic                     start;
  logic [IDX_W:0]           num_cols;
  logic                     theta_ren;
  logic [TADDR_W-1:0]       theta_addr;
  logic signed [DATA_W-1:0] theta_rdata;
  logic                     res_ren;
  logic [ROW_W-1:0]         res_addr;
  logic signed [DATA_W-1:0] res_rdata;
  logic                     corr_valid;
  logic signed [ACC_W-1:0]  corr_value;
  logic [IDX_W-1:0]         corr_idx;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, num_cols, theta_rdata, res_rdata,
    output theta_ren, theta_addr, res_ren, res_addr,
    output corr_valid, corr_value, corr_idx, busy, done
  );

  modport master (
    output start, num_cols, theta_rdata, res_rdata,
    input  theta_ren, theta_addr, res_ren, res_addr,
    input  corr_valid, corr_value, corr_idx, busy, done
  );
endinterface

// File: rtl/corr_scan.sv
// rtl/corr_scan.sv - streams the signed dot product of the residual with each theta column
module corr_scan #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int M_ROWS  = 32,
  parameter int N_COLS  = 256,
  parameter int IDX_W   = 8,
  parameter int ROW_W   = 5,
  parameter int TADDR_W = 13
) (
  input  logic       clk,
  input  logic       rst,
  corr_scan_if.slave io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M_ROWS - 1);
  localparam logic [IDX_W:0]   MAX_COLS = (IDX_W+1)'(N_COLS);

  state_t                  r_state;
  logic [IDX_W:0]          r_num_cols;
  logic [IDX_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic [TADDR_W-1:0]      r_taddr;
  logic                    r_ren;
  logic                    r_drain;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_d_valid;
  logic [ROW_W-1:0]        r_d_row;
  logic [IDX_W-1:0]        r_d_col;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_corr_value;
  logic [IDX_W-1:0]        r_corr_idx;
  logic                    r_corr_valid;

  logic [IDX_W:0]            w_num_clamped;
  logic                      w_last_issue;
  logic signed [2*DATA_W-1:0] w_theta_ext;
  logic signed [2*DATA_W-1:0] w_res_ext;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_next;

  assign w_num_clamped = (io_bus.num_cols > MAX_COLS) ? MAX_COLS : io_bus.num_cols;
  assign w_last_issue  = (r_row == LAST_ROW) &&
                         ({1'b0, r_col} == (r_num_cols - (IDX_W+1)'(1)));

  // Operands widened first so the product is computed at full 2*DATA_W precision
  assign w_theta_ext = {{DATA_W{io_bus.theta_rdata[DATA_W-1]}}, io_bus.theta_rdata};
  assign w_res_ext   = {{DATA_W{io_bus.res_rdata[DATA_W-1]}}, io_bus.res_rdata};
  assign w_prod      = w_theta_ext * w_res_ext;
  assign w_prod_ext  = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_acc_next  = (r_d_row == '0) ? w_prod_ext : (r_acc + w_prod_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_num_cols <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_taddr    <= '0;
      r_ren      <= 1'b0;
      r_drain    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            if (w_num_clamped != '0) begin
              r_num_cols <= w_num_clamped;
              r_col      <= '0;
              r_row      <= '0;
              r_taddr    <= '0;
              r_ren      <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          if (w_last_issue) begin
            r_ren   <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_taddr <= '0;
            r_drain <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            // Column-major layout makes the theta address a plain running count
            r_taddr <= r_taddr + TADDR_W'(1);
            if (r_row == LAST_ROW) begin
              r_row <= '0;
              r_col <= r_col + IDX_W'(1);
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid    <= 1'b0;
      r_d_row      <= '0;
      r_d_col      <= '0;
      r_acc        <= '0;
      r_corr_value <= '0;
      r_corr_idx   <= '0;
      r_corr_valid <= 1'b0;
    end else begin
      r_d_valid    <= r_ren;
      r_d_row      <= r_row;
      r_d_col      <= r_col;
      r_corr_valid <= 1'b0;
      if (r_d_valid) begin
        r_acc <= w_acc_next;
        if (r_d_row == LAST_ROW) begin
          r_corr_value <= w_acc_next;
          r_corr_idx   <= r_d_col;
          r_corr_valid <= 1'b1;
        end
      end
    end
  end

  assign io_bus.theta_ren  = r_ren;
  assign io_bus.theta_addr = r_taddr;
  assign io_bus.res_ren    = r_ren;
  assign io_bus.res_addr   = r_row;
  assign io_bus.corr_valid = r_corr_valid;
  assign io_bus.corr_value = r_corr_value;
  assign io_bus.corr_idx   = r_corr_idx;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
endmodule
